// File: rtl/dcpu2_core.sv
// dcpu2_core: multicycle CPU with 16-bit opcodes, a DW-bit datapath and a cs/ack memory bus.
// Define DCPU2_IRQ_EN to build the INT state, the IE bit, reti/ei/di and o_int_ack.
module dcpu2_core #(
   parameter int unsigned   DW       = 16,
   parameter logic [DW-1:0] RESET_PC = '0,
   parameter logic [DW-1:0] IRQ_VEC  = DW'(2)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic [DW-1:0] i_dat,
   output logic [DW-1:0] o_dat,
   output logic [DW-1:0] o_addr,
   output logic          o_we,
   output logic          o_cs,
   input  logic          i_ack,
   input  logic          i_int,
   output logic          o_int_ack
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_INT, S_HALT} state_t;
   localparam logic [DW-1:0] ONE = DW'(1);

   state_t        state, state_nxt;
   logic [15:0]   opcode;
   logic [DW-1:0] regs [16];

   logic [3:0]    rd, rs;
   logic [DW-1:0] pc, sp, sp_dec, ls_addr, rjp_off;
   logic          z_flag, c_flag, irq_take, cond_ok;
   logic          is_ldi, is_ldh, is_ld, is_st, is_rjp, is_jp, is_misc, is_alu, is_halt;
   logic          is_ret, is_push, is_pop, jp_call, exec_bus;
   logic [DW:0]   alu_full;
   logic          alu_wr;

   assign rd      = opcode[3:0];
   assign rs      = opcode[7:4];
   assign pc      = regs[15];
   assign sp      = regs[14];
   assign sp_dec  = sp - ONE;
   assign z_flag  = regs[13][0];
   assign c_flag  = regs[13][1];
   assign ls_addr = regs[rs] + {{(DW-5){opcode[12]}}, opcode[12:8]};
   assign rjp_off = {{(DW-9){opcode[11]}}, opcode[11:7], opcode[3:0]};

`ifdef DCPU2_IRQ_EN
   assign irq_take = i_int & regs[13][2];
`else
   logic unused_int;
   assign unused_int = i_int;
   assign irq_take   = 1'b0;
`endif

   assign is_ldi  = (opcode[15:14] == 2'b00);
   assign is_ldh  = (opcode[15:14] == 2'b01);
   assign is_ld   = (opcode[15:13] == 3'b100);
   assign is_st   = (opcode[15:13] == 3'b101);
   assign is_rjp  = (opcode[15:12] == 4'b1100);
   assign is_jp   = (opcode[15:8] == 8'hD0);
   assign is_misc = (opcode[15:8] == 8'hD1);
   assign is_alu  = (opcode[15:12] == 4'b1110);
   assign is_halt = (opcode == 16'hFFFF);
   // reti shares the ret bus transfer; only the IE update differs.
   assign is_ret  = is_misc && (opcode[7:4] == 4'd0 || opcode[7:4] == 4'd3);
   assign is_push = is_misc && (opcode[7:4] == 4'd1);
   assign is_pop  = is_misc && (opcode[7:4] == 4'd2);
   assign jp_call = is_jp && cond_ok && opcode[7];
   assign exec_bus = is_ld | is_st | is_ret | is_push | is_pop | jp_call;

   always_comb begin
      case (opcode[6:4])
         3'd0:    cond_ok = 1'b1;
         3'd1:    cond_ok = z_flag;
         3'd2:    cond_ok = ~z_flag;
         3'd3:    cond_ok = c_flag;
         3'd4:    cond_ok = ~c_flag;
         default: cond_ok = 1'b0;
      endcase
   end

   // alu_full[DW] carries C: carry, borrow or the shifted-out bit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_full = '0;
      alu_wr   = 1'b1;
      case (opcode[11:8])
         4'd0:    alu_full = {1'b0, regs[rd]} + {1'b0, regs[rs]};
         4'd1:    alu_full = {1'b0, regs[rd]} - {1'b0, regs[rs]};
         4'd2:    alu_full = {1'b0, regs[rd] & regs[rs]};
         4'd3:    alu_full = {1'b0, regs[rd] | regs[rs]};
         4'd4:    alu_full = {1'b0, regs[rd] ^ regs[rs]};
         4'd5:    alu_full = {1'b0, regs[rs]};
         4'd6:    alu_full = {regs[rd], 1'b0};
         4'd7:    alu_full = {regs[rd][0], 1'b0, regs[rd][DW-1:1]};
         default: alu_wr = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state <= S_FETCH;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: if (irq_take) state_nxt = S_INT;
                  else if (i_ack) state_nxt = S_EXEC;
         S_EXEC:  if (!exec_bus || i_ack) state_nxt = is_halt ? S_HALT : S_FETCH;
         S_INT:   if (i_ack) state_nxt = S_FETCH;
         S_HALT:  if (irq_take) state_nxt = S_INT;
         default: state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      o_cs      = 1'b0;
      o_we      = 1'b0;
      o_addr    = '0;
      o_dat     = '0;
      o_int_ack = 1'b0;
      if (i_reset_n) begin
         case (state)
            S_FETCH: if (!irq_take) begin
               o_cs   = 1'b1;
               o_addr = pc;
            end
            S_EXEC: begin
               if (is_ld || is_st) begin
                  o_cs   = 1'b1;
                  o_we   = is_st;
                  o_addr = ls_addr;
                  if (is_st) o_dat = regs[rd];
               end else if (is_ret || is_pop) begin
                  o_cs   = 1'b1;
                  o_addr = sp_dec;
               end else if (is_push || jp_call) begin
                  o_cs   = 1'b1;
                  o_we   = 1'b1;
                  o_addr = sp;
                  o_dat  = is_push ? regs[rd] : pc;
               end
            end
`ifdef DCPU2_IRQ_EN
            S_INT: begin
               o_cs      = 1'b1;
               o_we      = 1'b1;
               o_addr    = sp;
               o_dat     = pc;
               o_int_ack = i_ack;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         // NOTE: the register file is small and architecturally defined at reset, so it is cleared here.
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         regs[15] <= RESET_PC;
         opcode   <= '0;
      end else begin
         case (state)
            S_FETCH: if (!irq_take && i_ack) begin
               opcode   <= i_dat[15:0];
               regs[15] <= pc + ONE;
            end
            S_EXEC: begin
               if (is_ldi) begin
                  regs[rd] <= DW'(opcode[13:4]);
               end else if (is_ldh) begin
                  regs[rd][15:8] <= opcode[11:4];
               end else if (is_ld) begin
                  if (i_ack) regs[rd] <= i_dat;
               end else if (is_rjp) begin
                  if (cond_ok) regs[15] <= pc + rjp_off;
               end else if (is_jp) begin
                  if (jp_call) begin
                     if (i_ack) begin
                        regs[14] <= sp + ONE;
                        regs[15] <= regs[rd];
                     end
                  end else if (cond_ok) begin
                     regs[15] <= regs[rd];
                  end
               end else if (is_misc) begin
                  case (opcode[7:4])
                     4'd0, 4'd3: if (i_ack) begin
                        regs[14] <= sp_dec;
                        regs[15] <= i_dat;
`ifdef DCPU2_IRQ_EN
                        if (opcode[4]) regs[13][2] <= 1'b1;
`endif
                     end
                     4'd1: if (i_ack) regs[14] <= sp + ONE;
                     4'd2: if (i_ack) begin
                        regs[14] <= sp_dec;
                        regs[rd] <= i_dat;
                     end
`ifdef DCPU2_IRQ_EN
                     4'd4: regs[13][2] <= 1'b1;
                     4'd5: regs[13][2] <= 1'b0;
`endif
                     default: ;
                  endcase
               end else if (is_alu && alu_wr) begin
                  // NOTE: the later non-blocking write wins, so an ST destination overrides the flags.
                  regs[13][1:0] <= {alu_full[DW], (alu_full[DW-1:0] == '0)};
                  regs[rd]      <= alu_full[DW-1:0];
               end
            end
`ifdef DCPU2_IRQ_EN
            S_INT: if (i_ack) begin
               regs[14]    <= sp + ONE;
               regs[15]    <= IRQ_VEC;
               regs[13][2] <= 1'b0;
            end
`endif
            default: ;
         endcase
`ifndef DCPU2_IRQ_EN
         regs[13][2] <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_dcpu2_core.sv
// tb_dcpu2_core: directed programs for dcpu2_core against a wait-state-configurable memory model.
module tb_dcpu2_core;

   logic        clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic [15:0] i_dat, o_dat, o_addr;
   logic        o_we, o_cs, i_ack, i_int = 1'b0, o_int_ack;

   logic [15:0] mem [65536];
   int errors = 0, checks = 0;
   int nwait = 0, wcnt = 0;
   int bus_cycles = 0, wr_cycles = 0, ack_pulses = 0;

   always #5 clk = ~clk;

   assign i_dat = mem[o_addr];
   assign i_ack = (wcnt >= nwait);

   dcpu2_core #(.DW(16), .RESET_PC(16'h0000), .IRQ_VEC(16'h0030)) dut (
      .i_clk(clk), .i_reset_n(i_reset_n), .i_dat(i_dat), .o_dat(o_dat), .o_addr(o_addr),
      .o_we(o_we), .o_cs(o_cs), .i_ack(i_ack), .i_int(i_int), .o_int_ack(o_int_ack)
   );

   function automatic logic [15:0] f_ldi(input logic [9:0] imm, input logic [3:0] d);
      return {2'b00, imm, d};
   endfunction
   function automatic logic [15:0] f_ldh(input logic [7:0] imm, input logic [3:0] d);
      return {4'b0100, imm, d};
   endfunction
   function automatic logic [15:0] f_ld(input logic [4:0] o, input logic [3:0] s, input logic [3:0] d);
      return {3'b100, o, s, d};
   endfunction
   function automatic logic [15:0] f_st(input logic [4:0] o, input logic [3:0] s, input logic [3:0] d);
      return {3'b101, o, s, d};
   endfunction
   function automatic logic [15:0] f_rjp(input logic [8:0] o, input logic [2:0] c);
      return {4'b1100, o[8:4], c, o[3:0]};
   endfunction
   function automatic logic [15:0] f_jp(input logic b, input logic [2:0] c, input logic [3:0] d);
      return {8'hD0, b, c, d};
   endfunction
   function automatic logic [15:0] f_misc(input logic [3:0] op, input logic [3:0] d);
      return {8'hD1, op, d};
   endfunction
   function automatic logic [15:0] f_alu(input logic [3:0] op, input logic [3:0] s, input logic [3:0] d);
      return {4'hE, op, s, d};
   endfunction

   localparam logic [15:0] NOP  = 16'hF000;
   localparam logic [15:0] HALT = 16'hFFFF;

   // One clock per iteration: sample at negedge, update the memory model just after posedge.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         logic        do_wr;
         logic [15:0] wa, wd;
         int          nxt;
         #1;
         if (o_cs) bus_cycles++;
         if (o_cs && o_we) wr_cycles++;
         if (o_int_ack) ack_pulses++;
         do_wr = o_cs && o_we && i_ack;
         wa = o_addr;
         wd = o_dat;
         nxt = (!o_cs || i_ack) ? 0 : wcnt + 1;
         @(posedge clk);
         #1;
         if (do_wr) mem[wa] = wd;
         wcnt = nxt;
         @(negedge clk);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      i_reset_n = 1'b0;
      i_int = 1'b0;
      wcnt = 0;
      step(2);
      i_reset_n = 1'b1;
      bus_cycles = 0; wr_cycles = 0; ack_pulses = 0;
   endtask

   task automatic test_reset();
      clear_mem();
      mem[0] = f_ldi(10'h3FF, 4'd1);
      mem[1] = HALT;
      nwait = 0;
      i_reset_n = 1'b0;
      #1;
      checks++; if (o_cs !== 1'b0 || o_we !== 1'b0 || o_int_ack !== 1'b0) begin errors++; $display("FAIL reset_ctl: cs=%b we=%b int_ack=%b, required all 0", o_cs, o_we, o_int_ack); end
      checks++; if (o_addr !== 16'h0 || o_dat !== 16'h0) begin errors++; $display("FAIL reset_bus: addr=%h dat=%h, required 0000/0000", o_addr, o_dat); end
      step(2);
      checks++; if (dut.regs[15] !== 16'h0000 || dut.regs[1] !== 16'h0 || dut.regs[14] !== 16'h0) begin errors++; $display("FAIL reset_regs: pc=%h r1=%h sp=%h, required 0000/0000/0000", dut.regs[15], dut.regs[1], dut.regs[14]); end
      i_reset_n = 1'b1;
      #1;
      checks++; if (o_cs !== 1'b1 || o_addr !== 16'h0000) begin errors++; $display("FAIL first_fetch: cs=%b addr=%h, required 1/0000", o_cs, o_addr); end
      step(2);
      checks++; if (dut.regs[1] !== 16'h03FF) begin errors++; $display("FAIL ldi_r1: got %h, required 03ff", dut.regs[1]); end
      checks++; if (dut.regs[15] !== 16'h0001) begin errors++; $display("FAIL ldi_pc: got %h, required 0001", dut.regs[15]); end
   endtask

   task automatic test_reset_mid();
      clear_mem();
      mem[0] = f_ldi(10'h2AA, 4'd1);
      mem[1] = HALT;
      nwait = 3;
      do_reset();
      step(2);
      checks++; if (o_cs !== 1'b1 || dut.regs[15] !== 16'h0000) begin errors++; $display("FAIL mid_wait: cs=%b pc=%h, required 1/0000", o_cs, dut.regs[15]); end
      i_reset_n = 1'b0;
      #1;
      checks++; if (o_cs !== 1'b0) begin errors++; $display("FAIL mid_drop_cs: cs=%b, required 0", o_cs); end
      step(1);
      i_reset_n = 1'b1;
      nwait = 0;
      #1;
      checks++; if (o_cs !== 1'b1 || o_addr !== 16'h0000 || o_we !== 1'b0) begin errors++; $display("FAIL mid_refetch: cs=%b addr=%h we=%b, required 1/0000/0", o_cs, o_addr, o_we); end
      step(2);
      checks++; if (dut.regs[1] !== 16'h02AA) begin errors++; $display("FAIL mid_result: r1=%h, required 02aa", dut.regs[1]); end
   endtask

   task automatic test_ld_st();
      int wr_bad = 0;
      clear_mem();
      mem[0] = f_ldi(10'h010, 4'd0);
      mem[1] = f_ldi(10'h012, 4'd2);
      mem[2] = f_ldh(8'hAB, 4'd2);
      mem[3] = f_st(5'h1F, 4'd0, 4'd2);
      mem[4] = f_ld(5'h1F, 4'd0, 4'd3);
      mem[5] = HALT;
      nwait = 3;
      do_reset();
      for (int c = 0; c < 60; c++) begin
         if (o_cs && o_we && (o_addr !== 16'h000F || o_dat !== 16'hAB12)) wr_bad++;
         step(1);
      end
      checks++; if (mem[16'h000F] !== 16'hAB12) begin errors++; $display("FAIL st_mem: mem[000f]=%h, required ab12", mem[16'h000F]); end
      checks++; if (dut.regs[2] !== 16'hAB12) begin errors++; $display("FAIL ldh_r2: got %h, required ab12", dut.regs[2]); end
      checks++; if (wr_cycles !== 4) begin errors++; $display("FAIL st_we_hold: %0d write cycles, required 4", wr_cycles); end
      checks++; if (wr_bad !== 0) begin errors++; $display("FAIL st_stable: %0d unstable write cycles, required 0", wr_bad); end
      checks++; if (dut.regs[3] !== 16'hAB12) begin errors++; $display("FAIL ld_r3: got %h, required ab12", dut.regs[3]); end
      nwait = 0;
   endtask

   task automatic test_alu_branch();
      clear_mem();
      mem[0]  = f_ldi(10'h3FF, 4'd3);
      mem[1]  = f_ldh(8'hFF, 4'd3);
      mem[2]  = f_ldi(10'h001, 4'd4);
      mem[3]  = f_alu(4'd0, 4'd4, 4'd3);
      mem[4]  = f_rjp(9'd4, 3'd1);
      for (int a = 5; a < 9; a++) mem[a] = f_ldi(10'h111, 4'd6);
      mem[9]  = f_ldi(10'h055, 4'd7);
      mem[10] = f_jp(1'b1, 3'd2, 4'd5);
      mem[11] = HALT;
      do_reset();
      step(8);
      checks++; if (dut.regs[3] !== 16'h0000 || dut.regs[13] !== 16'h0003) begin errors++; $display("FAIL add_wrap: r3=%h st=%h, required 0000/0003", dut.regs[3], dut.regs[13]); end
      step(2);
      checks++; if (dut.regs[15] !== 16'h0009 || o_addr !== 16'h0009) begin errors++; $display("FAIL rjp_taken: pc=%h addr=%h, required 0009/0009", dut.regs[15], o_addr); end
      step(20);
      checks++; if (dut.regs[6] !== 16'h0 || dut.regs[7] !== 16'h0055) begin errors++; $display("FAIL rjp_skip: r6=%h r7=%h, required 0000/0055", dut.regs[6], dut.regs[7]); end
      checks++; if (wr_cycles !== 0 || dut.regs[14] !== 16'h0) begin errors++; $display("FAIL br_not_taken: writes=%0d sp=%h, required 0/0000", wr_cycles, dut.regs[14]); end
      checks++; if (bus_cycles !== 8 || dut.regs[15] !== 16'h000C) begin errors++; $display("FAIL fetch_count: bus=%0d pc=%h, required 8/000c", bus_cycles, dut.regs[15]); end
   endtask

   task automatic test_alu_ops();
      clear_mem();
      mem[0] = f_ldi(10'd5, 4'd1);
      mem[1] = f_ldi(10'd7, 4'd2);
      mem[2] = f_alu(4'd1, 4'd2, 4'd1);
      mem[3] = f_alu(4'd6, 4'd0, 4'd1);
      mem[4] = f_alu(4'd7, 4'd0, 4'd1);
      mem[5] = f_alu(4'd4, 4'd1, 4'd1);
      mem[6] = f_ldi(10'd3, 4'd5);
      mem[7] = f_alu(4'd5, 4'd5, 4'd13);
      mem[8] = HALT;
      do_reset();
      step(6);
      checks++; if (dut.regs[1] !== 16'hFFFE || dut.regs[13] !== 16'h0002) begin errors++; $display("FAIL sub_borrow: r1=%h st=%h, required fffe/0002", dut.regs[1], dut.regs[13]); end
      step(2);
      checks++; if (dut.regs[1] !== 16'hFFFC || dut.regs[13] !== 16'h0002) begin errors++; $display("FAIL shl_carry: r1=%h st=%h, required fffc/0002", dut.regs[1], dut.regs[13]); end
      step(2);
      checks++; if (dut.regs[1] !== 16'h7FFE || dut.regs[13] !== 16'h0000) begin errors++; $display("FAIL shr: r1=%h st=%h, required 7ffe/0000", dut.regs[1], dut.regs[13]); end
      step(2);
      checks++; if (dut.regs[1] !== 16'h0000 || dut.regs[13] !== 16'h0001) begin errors++; $display("FAIL xor_zero: r1=%h st=%h, required 0000/0001", dut.regs[1], dut.regs[13]); end
      step(4);
      checks++; if (dut.regs[13] !== 16'h0003) begin errors++; $display("FAIL mov_to_st: st=%h, required 0003", dut.regs[13]); end
   endtask

   task automatic test_call_ret();
      clear_mem();
      mem[0]     = f_ldi(10'h100, 4'd14);
      mem[1]     = f_ldi(10'h040, 4'd5);
      mem[2]     = f_rjp(9'd29, 3'd0);
      mem[16'h20] = f_jp(1'b1, 3'd0, 4'd5);
      mem[16'h21] = f_misc(4'd1, 4'd5);
      mem[16'h22] = f_misc(4'd2, 4'd11);
      mem[16'h23] = HALT;
      mem[16'h40] = f_misc(4'd0, 4'd0);
      do_reset();
      step(6);
      checks++; if (dut.regs[15] !== 16'h0020) begin errors++; $display("FAIL rjp_fwd: pc=%h, required 0020", dut.regs[15]); end
      step(2);
      checks++; if (mem[16'h100] !== 16'h0021 || dut.regs[14] !== 16'h0101 || dut.regs[15] !== 16'h0040) begin errors++; $display("FAIL br_call: mem=%h sp=%h pc=%h, required 0021/0101/0040", mem[16'h100], dut.regs[14], dut.regs[15]); end
      step(2);
      checks++; if (dut.regs[14] !== 16'h0100 || o_cs !== 1'b1 || o_we !== 1'b0 || o_addr !== 16'h0021) begin errors++; $display("FAIL ret: sp=%h cs=%b we=%b addr=%h, required 0100/1/0/0021", dut.regs[14], o_cs, o_we, o_addr); end
      step(4);
      checks++; if (mem[16'h100] !== 16'h0040 || dut.regs[11] !== 16'h0040 || dut.regs[14] !== 16'h0100) begin errors++; $display("FAIL push_pop: mem=%h r11=%h sp=%h, required 0040/0040/0100", mem[16'h100], dut.regs[11], dut.regs[14]); end
   endtask

   task automatic test_irq();
      clear_mem();
      mem[0]      = f_ldi(10'h100, 4'd14);
      mem[1]      = f_misc(4'd4, 4'd0);
      mem[2]      = NOP;
      mem[3]      = f_ldi(10'h077, 4'd8);
      mem[4]      = HALT;
      mem[16'h30] = f_ldi(10'h099, 4'd9);
      mem[16'h31] = f_misc(4'd3, 4'd0);
      do_reset();
      step(5);
      i_int = 1'b1;
`ifdef DCPU2_IRQ_EN
      step(1);
      checks++; if (o_cs !== 1'b0 || dut.regs[13][2] !== 1'b1) begin errors++; $display("FAIL irq_no_fetch: cs=%b ie=%b, required 0/1", o_cs, dut.regs[13][2]); end
      step(1);
      checks++; if (o_cs !== 1'b1 || o_we !== 1'b1 || o_addr !== 16'h0100 || o_dat !== 16'h0003 || o_int_ack !== 1'b1) begin errors++; $display("FAIL irq_push: cs=%b we=%b addr=%h dat=%h ack=%b, required 1/1/0100/0003/1", o_cs, o_we, o_addr, o_dat, o_int_ack); end
      i_int = 1'b0;
      step(1);
      checks++; if (o_addr !== 16'h0030 || dut.regs[13][2] !== 1'b0 || dut.regs[14] !== 16'h0101 || mem[16'h100] !== 16'h0003) begin errors++; $display("FAIL irq_vec: addr=%h ie=%b sp=%h mem=%h, required 0030/0/0101/0003", o_addr, dut.regs[13][2], dut.regs[14], mem[16'h100]); end
      step(4);
      checks++; if (o_addr !== 16'h0003 || dut.regs[13][2] !== 1'b1 || dut.regs[14] !== 16'h0100 || dut.regs[9] !== 16'h0099) begin errors++; $display("FAIL reti: addr=%h ie=%b sp=%h r9=%h, required 0003/1/0100/0099", o_addr, dut.regs[13][2], dut.regs[14], dut.regs[9]); end
      step(10);
      checks++; if (dut.regs[8] !== 16'h0077 || ack_pulses !== 1) begin errors++; $display("FAIL irq_resume: r8=%h pulses=%0d, required 0077/1", dut.regs[8], ack_pulses); end
`else
      step(1);
      checks++; if (o_cs !== 1'b1 || o_addr !== 16'h0003 || o_int_ack !== 1'b0) begin errors++; $display("FAIL irq_ignored: cs=%b addr=%h ack=%b, required 1/0003/0", o_cs, o_addr, o_int_ack); end
      step(12);
      i_int = 1'b0;
      checks++; if (dut.regs[8] !== 16'h0077 || dut.regs[9] !== 16'h0000 || dut.regs[13][2] !== 1'b0) begin errors++; $display("FAIL irq_off_flow: r8=%h r9=%h ie=%b, required 0077/0000/0", dut.regs[8], dut.regs[9], dut.regs[13][2]); end
      checks++; if (ack_pulses !== 0 || mem[16'h100] !== 16'h0000) begin errors++; $display("FAIL irq_off_bus: pulses=%0d mem=%h, required 0/0000", ack_pulses, mem[16'h100]); end
`endif
   endtask

   task automatic test_halt();
      clear_mem();
      mem[0]      = f_ldi(10'h100, 4'd14);
      mem[1]      = f_misc(4'd4, 4'd0);
      mem[2]      = HALT;
      mem[16'h30] = f_ldi(10'h05A, 4'd10);
      mem[16'h31] = HALT;
      do_reset();
      step(6);
      bus_cycles = 0;
      step(10);
      checks++; if (bus_cycles !== 0 || dut.regs[15] !== 16'h0003) begin errors++; $display("FAIL halt_idle: bus=%0d pc=%h, required 0/0003", bus_cycles, dut.regs[15]); end
      i_int = 1'b1;
`ifdef DCPU2_IRQ_EN
      step(1);
      checks++; if (o_cs !== 1'b1 || o_we !== 1'b1 || o_addr !== 16'h0100 || o_dat !== 16'h0003 || o_int_ack !== 1'b1) begin errors++; $display("FAIL halt_irq: cs=%b we=%b addr=%h dat=%h ack=%b, required 1/1/0100/0003/1", o_cs, o_we, o_addr, o_dat, o_int_ack); end
      i_int = 1'b0;
      step(10);
      checks++; if (dut.regs[10] !== 16'h005A || dut.regs[15] !== 16'h0032) begin errors++; $display("FAIL halt_handler: r10=%h pc=%h, required 005a/0032", dut.regs[10], dut.regs[15]); end
`else
      step(10);
      i_int = 1'b0;
      checks++; if (bus_cycles !== 0 || dut.regs[10] !== 16'h0000 || ack_pulses !== 0) begin errors++; $display("FAIL halt_stays: bus=%0d r10=%h pulses=%0d, required 0/0000/0", bus_cycles, dut.regs[10], ack_pulses); end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_ld_st();
      test_alu_branch();
      test_alu_ops();
      test_call_ret();
      test_irq();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
